// File: rtl/dlatch_bist_ctrl.sv
// Closed-loop self-test engine for a gated D latch: drives an 8-step en/d pattern,
// waits for the latch to settle, then checks Q/Qbar against a transparent-high golden latch.
module dlatch_bist_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             lat_d_o,
  output logic             lat_en_o,
  input  logic             lat_q_i,
  input  logic             lat_qbar_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             fail_vld_o,
  output logic [2:0]       fail_step_o
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    FIN
  } state_e;

  // Bit i of each table belongs to step i.
  localparam logic [7:0] PAT_EN = 8'b0101_0011;
  localparam logic [7:0] PAT_D  = 8'b0110_1010;
  localparam logic [7:0] PAT_Q  = 8'b1100_1110;

  localparam int              SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_q;
  logic [2:0]       step_q;
  logic [SW-1:0]    settle_q;
  logic             lat_d_q;
  logic             lat_en_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             fail_vld_q;
  logic [2:0]       fail_step_q;

  logic             chk_err_d;
  logic [CNT_W-1:0] err_cnt_d;

  // Expected Q comes from the fixed pattern, so one bad step never masks later ones.
  always_comb begin
    chk_err_d = (lat_q_i != PAT_Q[step_q]) || (lat_qbar_i == lat_q_i);
    err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      step_q      <= 3'd0;
      settle_q    <= '0;
      lat_d_q     <= 1'b0;
      lat_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_vld_q  <= 1'b0;
      fail_step_q <= 3'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            err_cnt_q   <= '0;
            fail_vld_q  <= 1'b0;
            fail_step_q <= 3'd0;
            pass_q      <= 1'b0;
            step_q      <= 3'd0;
            busy_q      <= 1'b1;
            state_q     <= DRIVE;
          end
        end
        DRIVE: begin
          lat_en_q <= PAT_EN[step_q];
          lat_d_q  <= PAT_D[step_q];
          settle_q <= SETTLE_LOAD;
          state_q  <= SETTLE;
        end
        SETTLE: begin
          if (settle_q == '0) begin
            state_q <= CHECK;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        CHECK: begin
          if (chk_err_d) begin
            err_cnt_q <= err_cnt_d;
            if (!fail_vld_q) begin
              fail_vld_q  <= 1'b1;
              fail_step_q <= step_q;
            end
          end
          step_q  <= step_q + 3'd1;
          state_q <= (step_q == 3'd7) ? FIN : DRIVE;
        end
        FIN: begin
          // The last CHECK has already landed in err_cnt_q, so pass covers all 8 steps.
          done_q   <= 1'b1;
          pass_q   <= (err_cnt_q == '0);
          busy_q   <= 1'b0;
          lat_en_q <= 1'b0;
          lat_d_q  <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lat_d_o     = lat_d_q;
  assign lat_en_o    = lat_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_cnt_o   = err_cnt_q;
  assign fail_vld_o  = fail_vld_q;
  assign fail_step_o = fail_step_q;

endmodule

// File: tb/tb_dlatch_bist_ctrl.sv
// Bench for dlatch_bist_ctrl: a faultable latch model feeds the engine, and a step-level
// reference model predicts err_cnt, fail_step and pass for each run.
module tb_dlatch_bist_ctrl;

  localparam int SETTLE   = 2;
  localparam int STEP_CYC = SETTLE + 2;
  localparam int RUN_CYC  = 8 * STEP_CYC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       latD, latEn, latQ, latQb;
  logic       busy, done, pass, failVld;
  logic [3:0] errCnt;
  logic [2:0] failStep;
  logic       latDS, latEnS, busyS, doneS, passS, failVldS;
  logic [1:0] errCntS;
  logic [2:0] failStepS;

  int   checks = 0;
  int   errors = 0;
  int   qMode  = 0;
  int   qbMode = 0;
  logic latchState = 1'b0;

  bit patEn [8] = '{1, 1, 0, 0, 1, 0, 1, 0};
  bit patD  [8] = '{0, 1, 0, 1, 0, 1, 1, 0};

  always #5 clk = ~clk;

  dlatch_bist_ctrl #(.SETTLE_CYC(SETTLE), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .lat_d_o(latD), .lat_en_o(latEn), .lat_q_i(latQ), .lat_qbar_i(latQb),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(errCnt),
    .fail_vld_o(failVld), .fail_step_o(failStep)
  );

  dlatch_bist_ctrl #(.SETTLE_CYC(SETTLE), .CNT_W(2)) dutSmall (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .lat_d_o(latDS), .lat_en_o(latEnS), .lat_q_i(latQ), .lat_qbar_i(latQb),
    .busy_o(busyS), .done_o(doneS), .pass_o(passS), .err_cnt_o(errCntS),
    .fail_vld_o(failVldS), .fail_step_o(failStepS)
  );

  // Latch under test, updated mid-cycle; qMode/qbMode plant faults on its outputs.
  always @(negedge clk) if (latEn) latchState <= latD;

  always_comb begin
    case (qMode)
      0:       latQ = latchState;
      1:       latQ = 1'b0;
      2:       latQ = 1'b1;
      3:       latQ = latD;
      default: latQ = ~latchState;
    endcase
    case (qbMode)
      0:       latQb = ~latQ;
      1:       latQb = latQ;
      default: latQb = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void refModel(input int qm, input int qbm,
                                   output int cnt, output bit fv, output int fs);
    bit g, q, qb, err;
    g   = 1'b0;
    cnt = 0;
    fv  = 1'b0;
    fs  = 0;
    for (int i = 0; i < 8; i++) begin
      if (patEn[i]) g = patD[i];
      case (qm)
        0:       q = g;
        1:       q = 1'b0;
        2:       q = 1'b1;
        3:       q = patD[i];
        default: q = !g;
      endcase
      case (qbm)
        0:       qb = !q;
        1:       qb = q;
        default: qb = 1'b0;
      endcase
      err = (q != g) || (qb == q);
      if (err) begin
        cnt++;
        if (!fv) begin
          fv = 1'b1;
          fs = i;
        end
      end
    end
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " lat_d"},     latD,     0);
    checkOutput({tag, " lat_en"},    latEn,    0);
    checkOutput({tag, " busy"},      busy,     0);
    checkOutput({tag, " done"},      done,     0);
    checkOutput({tag, " pass"},      pass,     0);
    checkOutput({tag, " err_cnt"},   errCnt,   0);
    checkOutput({tag, " fail_vld"},  failVld,  0);
    checkOutput({tag, " fail_step"}, failStep, 0);
  endtask

  // One run: accept start, optionally pulse start mid-run, optionally reset at cycle abortAt.
  task automatic applyStimulus(input int qm, input int qbm, input bit noise, input int abortAt);
    int cnt;
    bit fv;
    int fs;
    int s;
    qMode  = qm;
    qbMode = qbm;
    refModel(qm, qbm, cnt, fv, fs);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy after accept", busy, 1);
    for (int k = 1; k <= RUN_CYC + 1; k++) begin
      start = (noise && k <= RUN_CYC) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == abortAt) begin
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checkResetValues("abort");
        return;
      end
      tick();
      if (k < RUN_CYC && (k - 1) % STEP_CYC == 0) begin
        s = (k - 1) / STEP_CYC;
        checkOutput($sformatf("lat_en step%0d", s), latEn, patEn[s]);
        checkOutput($sformatf("lat_d step%0d", s),  latD,  patD[s]);
        checkOutput($sformatf("busy step%0d", s),   busy,  1);
      end
      if (k == RUN_CYC - 1) checkOutput("done early", done, 0);
      if (k == RUN_CYC) begin
        checkOutput("done at latency", done,      1);
        checkOutput("busy at done",    busy,      0);
        checkOutput("pass",            pass,      (cnt == 0) ? 1 : 0);
        checkOutput("err_cnt",         errCnt,    cnt);
        checkOutput("fail_vld",        failVld,   fv);
        checkOutput("fail_step",       failStep,  fs);
        checkOutput("err_cnt sat",     errCntS,   (cnt > 3) ? 3 : cnt);
        checkOutput("lat_en at end",   latEn,     0);
        checkOutput("lat_d at end",    latD,      0);
      end
      if (k == RUN_CYC + 1) begin
        checkOutput("done pulse width", done, 0);
        checkOutput("pass hold",        pass, (cnt == 0) ? 1 : 0);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    checkResetValues("reset");
    rst = 1'b0;
    tick();

    applyStimulus(0, 0, 1'b0, 0);
    applyStimulus(1, 0, 1'b0, 0);
    applyStimulus(3, 0, 1'b0, 0);
    applyStimulus(0, 1, 1'b0, 0);
    applyStimulus(0, 0, 1'b1, 0);
    applyStimulus(1, 0, 1'b0, 18);
    applyStimulus(0, 0, 1'b0, 0);

    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst over start busy", busy, 0);
    tick();
    checkOutput("rst over start idle", busy, 0);

    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
